// File: rtl/gpu_mem_pkg.sv
// Shared constants for the GPU memory fabric: bus geometry, bank field
// position in the address, and the core port state encoding.
package gpu_mem_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int N_BANKS = 16;
    localparam int N_CORES = 16;
    localparam int BANK_HI = 11;
    localparam int BANK_LO = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_RESP  = 2'd2;
    localparam state_t ST_GAP   = 2'd3;

endpackage

// File: rtl/req_fifo.sv
// Small synchronous FIFO with full/empty flags; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module req_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot that a push into a full FIFO needs.
    assign do_push = push && (!full || do_pop);
    assign dout    = slots[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) slots[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/core_mem_port.sv
// Per-core memory initiator: queues core requests, drives one at a time onto
// this core's slice of the bank arbiter buses and returns a response.
module core_mem_port
    import gpu_mem_pkg::*;
#(
    parameter int CORE_ID = 0,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int QDEPTH  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [N_BANKS-1:0]        bank_finish,
    input  logic [N_BANKS*DATA_W-1:0] bank_rdata,
    output logic                      busy
);

    localparam int FW = 1 + ADDR_W + DATA_W;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    if (CORE_ID < 0 || CORE_ID >= N_CORES) begin : g_bad_core_id
        $error("core_mem_port: CORE_ID out of range");
    end

    logic [FW-1:0]              head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;
    state_t                     state;
    logic [CW-1:0]              cnt;
    logic [BANK_HI-BANK_LO:0]   bank;
    logic                       hit;
    logic [DATA_W-1:0]          bank_word;

    req_fifo #(
        .WIDTH (FW),
        .DEPTH (QDEPTH)
    ) u_req_fifo (
        .clock (clock),
        .reset (reset),
        .push  (req_valid && req_ready),
        .din   ({req_we, req_addr, req_wdata}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign req_ready = !fifo_full;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign rsp_valid = (state == ST_RESP);
    assign busy      = !fifo_empty || (state != ST_IDLE);

    // Only the finish and data of the bank we are addressing matter.
    assign bank      = mem_addr[BANK_HI:BANK_LO];
    assign hit       = bank_finish[bank];
    assign bank_word = bank_rdata[bank * DATA_W +: DATA_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        mem_read  <= !head[FW-1];
                        mem_write <= head[FW-1];
                        mem_addr  <= head[FW-2 -: ADDR_W];
                        mem_wdata <= head[DATA_W-1:0];
                        cnt       <= '0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A finish in the expiry cycle still completes normally.
                    if (hit) begin
                        rsp_rdata <= mem_write ? '0 : bank_word;
                        rsp_err   <= 1'b0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        state     <= ST_RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) state <= ST_GAP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
